// File: rtl/rra_pkg.sv
// Shared definitions for the request-queue bank that feeds the RRA round-robin arbiter.
package rra_pkg;

    localparam int NUM_REQ_DEFAULT = 4;

    typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] idx_t;

    // Exactly one bit set; callers zero-extend narrower vectors.
    function automatic logic onehot_chk(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Single DATA_W x DEPTH FIFO with power-of-two wrapping pointers and an explicit occupancy count.
module req_fifo
    import rra_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW + 1)'(DEPTH));

endmodule

// File: rtl/req_queue_bank.sv
// Per-requester FIFOs upstream of the round-robin arbiter; one registered pop output per grant.
// Optional macro GNT_ERR_EN adds a sticky gnt_err flag for malformed or empty-queue grants.
module req_queue_bank
    import rra_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           push_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    push_data,
    output logic [NUM_REQ-1:0]           push_ready,
    output logic [NUM_REQ-1:0]           REQ,
    input  logic [NUM_REQ-1:0]           GNT,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_REQ)-1:0]   out_id
`ifdef GNT_ERR_EN
    ,
    output logic                         gnt_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     full;
    logic [NUM_REQ-1:0]     empty;
    logic [NUM_REQ-1:0]     push_en;
    logic [NUM_REQ-1:0]     pop_en;
    logic [DATA_W-1:0]      head [NUM_REQ];
    logic                   gnt_onehot;
    logic [IDX_W-1:0]       sel_id_p0;
    logic [DATA_W-1:0]      sel_data_p0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        logic [$clog2(DEPTH):0] count_unused;
        req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_en[i]),
            .push_data (push_data[i*DATA_W +: DATA_W]),
            .pop       (pop_en[i]),
            .head_data (head[i]),
            .count     (count_unused),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end

    // A full queue refuses a push even when it is popped in the same cycle.
    assign push_ready = ~full;
    assign REQ        = ~empty;
    assign push_en    = push_valid & ~full;

    assign gnt_onehot = onehot_chk(32'(GNT));
    assign pop_en     = gnt_onehot ? (GNT & REQ) : '0;

    always_comb begin
        sel_id_p0   = '0;
        sel_data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop_en[i]) begin
                sel_id_p0   = IDX_W'(i);
                sel_data_p0 = head[i];
            end
        end
    end

    // p0 -> output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            out_valid <= |pop_en;
            if (|pop_en) begin
                out_data <= sel_data_p0;
                out_id   <= sel_id_p0;
            end
        end
    end

`ifdef GNT_ERR_EN
    // An idle GNT=0 is legal; multi-hot or a grant to an empty queue is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_err <= 1'b0;
        end else if ((GNT != '0) && (!gnt_onehot || ((GNT & ~REQ) != '0))) begin
            gnt_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_req_queue_bank.sv
// Randomized scoreboard bench for req_queue_bank against a queue-based reference model.
module tb_req_queue_bank;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    push_valid;
    logic [N*DW-1:0] push_data;
    logic [N-1:0]    push_ready;
    logic [N-1:0]    REQ;
    logic [N-1:0]    GNT;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
`ifdef GNT_ERR_EN
    logic            gnt_err;
    logic            exp_err;
`endif

    req_queue_bank #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .REQ        (REQ),
        .GNT        (GNT),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id)
`ifdef GNT_ERR_EN
        ,
        .gnt_err    (gnt_err)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: one queue of words per requester, plus expected outputs in order.
    logic [DW-1:0] mq [N][$];
    logic [DW-1:0] sb_data [$];
    logic [1:0]    sb_id [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        sb_data.delete();
        sb_id.delete();
`ifdef GNT_ERR_EN
        exp_err = 1'b0;
`endif
    endfunction

    // Called at a falling edge: check REQ/push_ready, drive, advance the model, wait one cycle.
    task automatic cycle(input logic [N-1:0] pv, input logic [N*DW-1:0] pd, input logic [N-1:0] g);
        logic [N-1:0] exp_req, exp_rdy;
        int gi;
        for (int i = 0; i < N; i++) begin
            exp_req[i] = (mq[i].size() != 0);
            exp_rdy[i] = (mq[i].size() != D);
        end
        check("req", 32'(REQ), 32'(exp_req));
        check("push_ready", 32'(push_ready), 32'(exp_rdy));
`ifdef GNT_ERR_EN
        check("gnt_err", 32'(gnt_err), 32'(exp_err));
`endif
        push_valid = pv;
        push_data  = pd;
        GNT        = g;
        gi = -1;
        for (int i = 0; i < N; i++) if (g[i]) gi = i;
`ifdef GNT_ERR_EN
        if (g != '0 && ($countones(g) != 1 || mq[gi].size() == 0)) exp_err = 1'b1;
`endif
        if ($countones(g) == 1 && mq[gi].size() != 0) begin
            sb_data.push_back(mq[gi].pop_front());
            sb_id.push_back(2'(gi));
        end
        for (int i = 0; i < N; i++)
            if (pv[i] && exp_rdy[i]) mq[i].push_back(pd[i*DW +: DW]);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, exactly the scheduled pop (or nothing) must appear.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_data.size() == 0) begin
                check("idle_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_valid", 32'(out_valid), 32'd1);
                check("out_data", 32'(out_data), 32'(sb_data.pop_front()));
                check("out_id", 32'(out_id), 32'(sb_id.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]    pv, g;
        logic [N*DW-1:0] pd;
        int r;
        rst_n = 1'b0;
        push_valid = '0;
        push_data = '0;
        GNT = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req", 32'(REQ), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'hF);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        rst_n = 1'b1;
        repeat (2) cycle('0, '0, '0);

        // Single push to FIFO 3 then grant it.
        pd = '0;
        pd[3*DW +: DW] = 8'hA5;
        cycle(4'b1000, pd, '0);
        cycle('0, '0, 4'b1000);
        cycle('0, '0, '0);

        // Fill FIFO 1, then pop while pushing into the full queue.
        for (int k = 0; k < 5; k++) begin
            pd = '0;
            pd[1*DW +: DW] = 8'(8'h10 + k);
            cycle(4'b0010, pd, '0);
        end
        cycle(4'b0010, pd, 4'b0010);
        cycle('0, '0, 4'b0011);
        cycle('0, '0, 4'b0100);
        repeat (4) cycle('0, '0, 4'b0010);

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                #1;
                check("midrst_req", 32'(REQ), 32'd0);
                check("midrst_out_valid", 32'(out_valid), 32'd0);
                model_reset();
                push_valid = '0;
                GNT = '0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            pv = N'($urandom_range(0, 15));
            pd = {$urandom(), $urandom()};
            r = $urandom_range(0, 9);
            if (r < 5)       g = N'(1 << $urandom_range(0, N - 1));
            else if (r == 5) g = N'($urandom_range(0, 15));
            else             g = '0;
            cycle(pv, pd, g);
        end
        for (int k = 0; k < 4 * D; k++) cycle('0, '0, N'(1 << (k % N)));
        cycle('0, '0, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
